// File: rtl/pixel_frame_sequencer.sv
// Raster-order frame reader: issues memory reads for one IMG_W x IMG_H frame,
// absorbs the 1-cycle read latency in a 2-entry skid buffer, streams pixels out.
module pixel_frame_sequencer #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    input  logic              pix_ready,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     LAST_ROW  = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] rd_cnt;
    logic              in_flight;
    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;
    logic [1:0]        count;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [2:0]        occupancy;
    logic              pop;
    logic              issue;
    logic              frame_start;
    logic              last_read;

    assign pix_valid   = (count != 2'd0);
    assign pix_data    = pix_valid ? entry0 : '0;
    assign pop         = pix_valid & pix_ready;
    assign sof         = pix_valid && (row == '0) && (col == '0);
    assign eol         = pix_valid && (col == LAST_COL);
    assign eof         = eol && (row == LAST_ROW);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign frame_start = (state == IDLE) && start;

    // A read is a credit: buffered + outstanding entries may never exceed two,
    // counting a pixel leaving this cycle as already gone.
    assign occupancy = {1'b0, count} + {2'b00, in_flight};
    assign issue     = (state == RUN) && (occupancy < (3'd2 + {2'b00, pop}));
    assign mem_rd_en = issue;
    assign mem_addr  = rd_cnt;
    assign last_read = issue && (rd_cnt == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_read) state_next = DRAIN;
            DRAIN:   if (pop && eof) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt    <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (frame_start) begin
                rd_cnt <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + ADDR_W'(1);
            end
        end
    end

    // entry0 is always the head; a pop shifts entry1 forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({in_flight, pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= mem_rdata;
                    else               entry1 <= mem_rdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= mem_rdata;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Scoreboard bench for pixel_frame_sequencer on a 4x3 frame with a behavioural
// 1-cycle-latency memory holding mem[i] = 3*i+1.
module tb_pixel_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pix_ready = 1'b1;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          sof, eol, eof, busy, done;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         total = 0;
    int         bad = 0;
    int         sb_idx = 0;
    int         frames_done = 0;
    int         xfers = 0;
    int         rd_issued = 0;
    int         cycle = 0;
    int         sof_cycle = 0;
    int         exp_addr = 0;
    bit         full_rate = 1'b0;
    bit         expect_done = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] held = '0;

    pixel_frame_sequencer #(
        .IMG_W (W),
        .IMG_H (H),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem_rd_en(mem_rd_en),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .pix_ready(pix_ready),
        .sof      (sof),
        .eol      (eol),
        .eof      (eof),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input int a);
        return 8'(a * 3 + 1);
    endfunction

    // Returns data one cycle after a read; junk otherwise so stray captures show.
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? mem_val(int'(mem_addr)) : 8'hEE;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    task automatic failNote(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: bound expired at cycle %0d", name, cycle);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_valid"}, 32'(pix_valid), 32'd0);
        checkOutput({tag, "_data"}, 32'(pix_data), 32'd0);
        checkOutput({tag, "_markers"}, 32'({sof, eol, eof}), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Queue one frame's expected pixels, then pulse (or hold) start.
    task automatic applyStimulus(input bit hold);
        exp_t x;
        for (int i = 0; i < N; i++) begin
            x.data = mem_val(i);
            x.sof  = (i == 0);
            x.eol  = ((i % W) == W - 1);
            x.eof  = (i == N - 1);
            exp_q.push_back(x);
        end
        @(posedge clk);
        #2 start = 1'b1;
        pix_ready = 1'b1;
        @(posedge clk);
        #2;
        if (!hold) start = 1'b0;
    endtask

    task automatic checkLatency();
        @(negedge clk);
        checkOutput("lat_rd_en_c1", 32'(mem_rd_en), 32'd1);
        checkOutput("lat_busy_c1", 32'(busy), 32'd1);
        checkOutput("lat_valid_c1", 32'(pix_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_valid_c2", 32'(pix_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_valid_c3", 32'(pix_valid), 32'd1);
    endtask

    // mode 0: ready high, 1: ready low 5 cycles while pixel 2 is presented, 2: random.
    task automatic waitFrame(input int mode, input int budget);
        int  target = frames_done + 1;
        int  bp = 0;
        bit  did = 1'b0;
        bit  ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #2;
            if (frames_done >= target) begin
                ok = 1'b1;
                start = 1'b0;
                pix_ready = 1'b1;
                break;
            end
            if (mode == 1) begin
                if (!did && xfers == 2) begin
                    did = 1'b1;
                    bp = 5;
                end
                pix_ready = (bp > 0) ? 1'b0 : 1'b1;
                if (bp > 0) bp--;
            end else if (mode == 2) begin
                pix_ready = 1'($urandom_range(0, 1));
            end else begin
                pix_ready = 1'b1;
            end
        end
        if (!ok) begin
            failNote("frame_timeout");
            start = 1'b0;
            pix_ready = 1'b1;
        end
    endtask

    task automatic waitXfers(input int n, input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #2;
            pix_ready = 1'b1;
            if (xfers == n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNote("xfer_timeout");
    endtask

    task automatic idleCheck(input string name, input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
        checkOutput(name, 32'({busy, pix_valid, mem_rd_en}), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every transfer and watches the protocol.
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            sb_idx      = exp_q.size();
            expect_done = 1'b0;
            stalled     = 1'b0;
            exp_addr    = 0;
            rd_issued   = 0;
            xfers       = 0;
        end else begin
            if (expect_done) begin
                checkOutput("done_pulse", 32'(done), 32'd1);
                checkOutput("busy_after_done", 32'(busy), 32'd0);
                expect_done = 1'b0;
            end else if (done) begin
                checkOutput("spurious_done", 32'(done), 32'd0);
            end
            if (done) frames_done++;
            if (!busy) begin
                exp_addr  = 0;
                rd_issued = 0;
                xfers     = 0;
            end
            if (mem_rd_en) begin
                checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr++;
                rd_issued++;
            end
            if (stalled) begin
                checkOutput("stall_valid", 32'(pix_valid), 32'd1);
                checkOutput("stall_data", 32'(pix_data), 32'(held));
            end
            stalled = 1'b0;
            if (pix_valid) begin
                if (pix_ready) begin
                    if (sb_idx >= exp_q.size()) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL extra_pixel: got %0h required none at cycle %0d", pix_data, cycle);
                    end else begin
                        e = exp_q[sb_idx];
                        sb_idx++;
                        checkOutput("pix_data", 32'(pix_data), 32'(e.data));
                        checkOutput("markers", 32'({sof, eol, eof}), 32'({e.sof, e.eol, e.eof}));
                        if (sof) sof_cycle = cycle;
                        if (eof) begin
                            expect_done = 1'b1;
                            if (full_rate) checkOutput("full_rate_span", 32'(cycle - sof_cycle), 32'(N - 1));
                        end
                    end
                    xfers++;
                end else begin
                    stalled = 1'b1;
                    held    = pix_data;
                end
            end else begin
                checkOutput("idle_markers", 32'({sof, eol, eof}), 32'd0);
            end
            checkOutput("credit_bound", 32'((rd_issued - xfers) <= 2), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        checkResetOutputs("por");
        @(posedge clk);
        #2;
        @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] frame 1: full rate");
        full_rate = 1'b1;
        applyStimulus(1'b0);
        checkLatency();
        waitFrame(0, 100);
        full_rate = 1'b0;
        idleCheck("idle_after_f1", 3);

        $display("[TB] frame 2: backpressure on pixel 2");
        applyStimulus(1'b0);
        waitFrame(1, 100);

        $display("[TB] frames 3-5: random ready");
        repeat (3) begin
            applyStimulus(1'b0);
            waitFrame(2, 300);
        end

        $display("[TB] start held high through a frame");
        applyStimulus(1'b1);
        waitFrame(0, 100);
        idleCheck("idle_after_hold", 8);

        $display("[TB] start re-pulsed mid-frame");
        applyStimulus(1'b0);
        waitXfers(3, 50);
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        waitFrame(0, 100);
        idleCheck("idle_after_repulse", 8);

        $display("[TB] reset at pixel 5");
        applyStimulus(1'b0);
        waitXfers(5, 50);
        #1 rst = 1'b1;
        #1 checkResetOutputs("mid_rst");
        @(posedge clk);
        #2 rst = 1'b0;
        idleCheck("idle_after_rst", 2);
        full_rate = 1'b1;
        applyStimulus(1'b0);
        checkLatency();
        waitFrame(0, 100);
        full_rate = 1'b0;
        idleCheck("idle_final", 4);

        checkOutput("sb_drained", 32'(sb_idx), 32'(exp_q.size()));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_frame_sequencer.md
Name: pixel_frame_sequencer

Overview:
Frame-level controller that feeds the pixel pass-through datapath from a synchronous frame memory. On a start pulse it generates read addresses in raster order for one IMG_W x IMG_H frame. It absorbs the 1-cycle memory read latency in a 2-entry skid buffer and presents pixels on a valid/ready stream. Each pixel carries start-of-frame, end-of-line and end-of-frame markers.

Parameters:
IMG_W, 256, pixels per line (>=2)
IMG_H, 256, lines per frame (>=2)
ADDR_W, 16, memory address width (2^ADDR_W >= IMG_W*IMG_H)
DATA_W, 8, pixel width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  begin one frame; sampled only in IDLE
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  read address, valid when mem_rd_en=1
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
pix_valid  out  1  pixel available
pix_data  out  DATA_W  pixel value
pix_ready  in  1  downstream accepts pixel; transfer = pix_valid & pix_ready
sof  out  1  qualifies pix_valid: pixel (row 0, col 0)
eol  out  1  qualifies pix_valid: col = IMG_W-1
eof  out  1  qualifies pix_valid: last pixel of frame
busy  out  1  high in RUN and DRAIN
done  out  1  single-cycle pulse after last transfer

Behaviour:
- Reset (async assert, sync release): state=IDLE; mem_rd_en=0, mem_addr=0, pix_valid=0, pix_data=0, sof=eol=eof=0, busy=0, done=0; buffer empty; read counter, in-flight flag and output row/col counters cleared. Reset mid-frame abandons the frame. In-flight memory data is discarded.
- FSM: IDLE -> RUN on start=1. RUN -> DRAIN in the cycle the final read (addr IMG_W*IMG_H-1) is issued. DRAIN -> DONE when the eof transfer occurs. DONE -> IDLE after 1 cycle, with done=1 during DONE. start is ignored outside IDLE.
- Read issue: mem_rd_en=1 in RUN when credit allows, i.e. (buffer count + in_flight - pop) < 2, where pop = pix_valid & pix_ready in the current cycle. mem_addr starts at 0 and increments by 1 per issued read. No wrap within a frame. Reset to 0 at frame start.
- Capture: data returning 1 cycle after mem_rd_en is written to the 2-entry skid buffer. Capture and pop in the same cycle are both honoured; occupancy is unchanged. Overflow is impossible by the credit rule. The bench asserts this.
- Output: pix_valid = buffer non-empty, and pix_data = head entry. pix_data/pix_valid stay stable while pix_valid=1 and pix_ready=0.
- Markers are computed from output-side col/row counters, which advance only on transfer. col wraps at IMG_W-1 to 0, and then row increments. sof = (row==0 && col==0), eol = (col==IMG_W-1), eof = eol && row==IMG_H-1. All are 0 when pix_valid=0.
- Latency: start sampled at cycle 0 -> first mem_rd_en at cycle 1 -> first pix_valid at cycle 3.
- Throughput: 1 pixel/cycle with pix_ready held high.
- busy rises the cycle after start and falls the cycle done is asserted.

Test Plan:
- IMG_W=4, IMG_H=3, mem[i]=i, pix_ready=1: start pulse -> 12 pixels 0..11 on consecutive cycles from cycle 3. sof on pixel 0. eol on 3, 7, 11. eof on 11. done 1 cycle after pixel 11. busy low afterwards.
- Backpressure: pix_ready low for 5 cycles after pixel 2 -> pix_data holds 2, mem_rd_en stops after buffer+in-flight reach 2, no pixel lost or duplicated, sequence resumes 3..11.
- Random pix_ready at 50% over a 16x8 frame -> output equals mem[0..127] in order, markers correct, buffer never exceeds 2.
- start held high through a frame and re-pulsed mid-frame -> exactly one frame per IDLE start. A second frame starts only after done. Addresses restart at 0.
- rst asserted at pixel 5 of the 4x3 frame -> all outputs 0 asynchronously, state IDLE. A new start yields a clean frame 0..11 with sof on pixel 0.
- Simultaneous capture and pop with buffer count=1 (pix_ready=1 in steady state) -> count stays 1, no bubble, no drop.
